// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode/funct values, datapath select codes and the instruction classes.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_OR  = 2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;
  localparam logic [1:0] WD_LUI = 2'd3;

  // Bit positions in the one-hot class vector.
  typedef enum logic [3:0] {
    CL_ADDU = 4'd0,
    CL_SUBU = 4'd1,
    CL_JR   = 4'd2,
    CL_ORI  = 4'd3,
    CL_LW   = 4'd4,
    CL_SW   = 4'd5,
    CL_BEQ  = 4'd6,
    CL_LUI  = 4'd7,
    CL_J    = 4'd8,
    CL_JAL  = 4'd9
  } cls_e;

  localparam int NCLS = 10;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder: one-hot instruction class plus an
// illegal flag when nothing matches.
module mc_decode
  import mc_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic [OP_W-1:0] op,
  input  logic [FN_W-1:0] funct,
  output logic [NCLS-1:0] cls_oh,
  output logic            illegal
);

  always_comb begin
    cls_oh = '0;
    if (op == OP_W'(OP_RTYPE)) begin
      case (funct)
        FN_W'(FN_ADDU): cls_oh[CL_ADDU] = 1'b1;
        FN_W'(FN_SUBU): cls_oh[CL_SUBU] = 1'b1;
        FN_W'(FN_JR):   cls_oh[CL_JR]   = 1'b1;
        default:        cls_oh          = '0;
      endcase
    end else begin
      case (op)
        OP_W'(OP_ORI): cls_oh[CL_ORI] = 1'b1;
        OP_W'(OP_LW):  cls_oh[CL_LW]  = 1'b1;
        OP_W'(OP_SW):  cls_oh[CL_SW]  = 1'b1;
        OP_W'(OP_BEQ): cls_oh[CL_BEQ] = 1'b1;
        OP_W'(OP_LUI): cls_oh[CL_LUI] = 1'b1;
        OP_W'(OP_J):   cls_oh[CL_J]   = 1'b1;
        OP_W'(OP_JAL): cls_oh[CL_JAL] = 1'b1;
        default:       cls_oh         = '0;
      endcase
    end
    illegal = ~|cls_oh;
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller sequencing FETCH/DECODE/EXEC/MEM/WB.
// Define MC_ILLEGAL_TRAP_EN to lock into TRAP on an unrecognised instruction.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FN_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    instr_op,
  input  logic [FN_W-1:0]    instr_funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_sel,
  output logic               mem_we,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wd_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_b,
  output logic               ext_sign,
  output logic               instr_done,
  output logic [2:0]         state
);

  // Memory handshake: mem_req rises with the request and stays high until the
  // cycle mem_ready is seen; that cycle completes the access. mem_ready is
  // ignored whenever mem_req is low.

  state_e            state_q, state_d;
  logic [NCLS-1:0]   cls_q;
  logic [NCLS-1:0]   dec_oh;
  logic              dec_illegal;

  mc_decode #(.OP_W(OP_W), .FN_W(FN_W)) u_decode (
    .op      (instr_op),
    .funct   (instr_funct),
    .cls_oh  (dec_oh),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) cls_q <= dec_oh;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    reg_we     = 1'b0;
    reg_dst    = RD_RT;
    wd_sel     = WD_ALU;
    alu_op     = ALUOP_W'(ALU_ADD);
    alu_src_b  = 1'b0;
    ext_sign   = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_src  = PC_PLUS4;
          state_d = ST_DECODE;
        end
      end
      // The IR is valid here, so DECODE acts on the live decode, not cls_q.
      ST_DECODE: begin
        if (dec_illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end else if (dec_oh[CL_J]) begin
          pc_we   = 1'b1;
          pc_src  = PC_JUMP;
          state_d = ST_FETCH;
        end else if (dec_oh[CL_JAL]) begin
          reg_we  = 1'b1;
          reg_dst = RD_RA;
          wd_sel  = WD_PC;
          pc_we   = 1'b1;
          pc_src  = PC_JUMP;
          state_d = ST_FETCH;
        end else if (dec_oh[CL_JR]) begin
          pc_we   = 1'b1;
          pc_src  = PC_RS;
          state_d = ST_FETCH;
        end else if (dec_oh[CL_LUI]) begin
          reg_we  = 1'b1;
          reg_dst = RD_RT;
          wd_sel  = WD_LUI;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
        if (cls_q[CL_SUBU]) begin
          alu_op = ALUOP_W'(ALU_SUB);
        end else if (cls_q[CL_ORI]) begin
          alu_op    = ALUOP_W'(ALU_OR);
          alu_src_b = 1'b1;
        end else if (cls_q[CL_LW] || cls_q[CL_SW]) begin
          alu_src_b = 1'b1;
          ext_sign  = 1'b1;
          state_d   = ST_MEM;
        end else if (cls_q[CL_BEQ]) begin
          alu_op  = ALUOP_W'(ALU_SUB);
          pc_we   = alu_zero;
          pc_src  = PC_BRANCH;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = cls_q[CL_SW];
        if (mem_ready) state_d = cls_q[CL_SW] ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        reg_we = 1'b1;
        if (cls_q[CL_ADDU] || cls_q[CL_SUBU]) reg_dst = RD_RD;
        else if (cls_q[CL_LW])                 wd_sel  = WD_MDR;
        state_d = ST_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_FETCH;
    endcase

    instr_done = (state_q != ST_FETCH) && (state_d == ST_FETCH);

    // Reset gates every output combinationally so an abort drops mem_req at once.
    if (!reset_n) begin
      mem_req    = 1'b0;
      mem_sel    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_PLUS4;
      reg_we     = 1'b0;
      reg_dst    = RD_RT;
      wd_sel     = WD_ALU;
      alu_op     = ALUOP_W'(ALU_ADD);
      alu_src_b  = 1'b0;
      ext_sign   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: random instruction stream with random
// memory wait states, plus directed reset-abort and illegal-instruction steps.
module tb_mc_ctrl_fsm;

  localparam int W = 21;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] instr_op;
  logic [5:0] instr_funct;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_sel, mem_we, ir_we, pc_we, reg_we;
  logic [1:0] pc_src, reg_dst, wd_sel;
  logic [2:0] alu_op;
  logic       alu_src_b, ext_sign, instr_done;
  logic [2:0] dut_state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  int           rdy_q[$];

  string cls_name[11] = '{"addu", "subu", "jr", "ori", "lw", "sw", "beq",
                          "lui", "j", "jal", "ill"};

  mc_ctrl_fsm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_op    (instr_op),
    .instr_funct (instr_funct),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_sel     (mem_sel),
    .mem_we      (mem_we),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .reg_we      (reg_we),
    .reg_dst     (reg_dst),
    .wd_sel      (wd_sel),
    .alu_op      (alu_op),
    .alu_src_b   (alu_src_b),
    .ext_sign    (ext_sign),
    .instr_done  (instr_done),
    .state       (dut_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs_vec();
    return {dut_state, mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src, reg_we,
            reg_dst, wd_sel, alu_op, alu_src_b, ext_sign, instr_done};
  endfunction

  // Expected-output record in the same field order as obs_vec.
  function automatic logic [W-1:0] mk(
    input int st, input bit req, input bit sel, input bit we, input bit irw,
    input bit pcw, input int pcs, input bit rw, input int rd, input int wd,
    input int alu, input bit sb, input bit es, input bit dn);
    logic [2:0] st3 = 3'(st);
    logic [1:0] pcs2 = 2'(pcs);
    logic [1:0] rd2 = 2'(rd);
    logic [1:0] wd2 = 2'(wd);
    logic [2:0] alu3 = 3'(alu);
    return {st3, req, sel, we, irw, pcw, pcs2, rw, rd2, wd2, alu3, sb, es, dn};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // Instruction encoding for each class; non-R classes carry a random funct.
  task automatic encode(input int k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom_range(0, 63));
    case (k)
      K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_ORI:  op = 6'b001101;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_LUI:  op = 6'b001111;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: begin
        if ($urandom_range(0, 1) == 1) op = 6'b111111;
        else begin op = 6'b000000; fn = 6'b000000; end
      end
    endcase
  endtask

  // Reference model: the per-cycle output trace of one instruction derived
  // from its class, the FETCH/MEM wait counts and alu_zero.
  // rdy_q: 0 = drive mem_ready low, 1 = drive high, 2 = random (no request).
  task automatic build_exp(input int k, input int fw, input int mw, input bit z);
    bit is_r   = (k == K_ADDU) || (k == K_SUBU);
    bit is_mem = (k == K_LW) || (k == K_SW);
    bit is_sw  = (k == K_SW);
    exp_q.delete();
    rdy_q.delete();
    repeat (fw) begin
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); rdy_q.push_back(0);
    end
    exp_q.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); rdy_q.push_back(1);
    case (k)
      K_J:   exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
      K_JAL: exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, 2, 2, 0, 0, 0, 1));
      K_JR:  exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1));
      K_LUI: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1));
      K_ILL: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      default: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endcase
    rdy_q.push_back(2);
    if (k == K_J || k == K_JAL || k == K_JR || k == K_LUI || k == K_ILL) return;
    case (k)
      K_ADDU: exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      K_SUBU: exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      K_ORI:  exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      K_BEQ:  exp_q.push_back(mk(2, 0, 0, 0, 0, z, 1, 0, 0, 0, 1, 0, 0, 1));
      default: exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    endcase
    rdy_q.push_back(2);
    if (k == K_BEQ) return;
    if (is_mem) begin
      repeat (mw) begin
        exp_q.push_back(mk(3, 1, 1, is_sw, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); rdy_q.push_back(0);
      end
      exp_q.push_back(mk(3, 1, 1, is_sw, 0, 0, 0, 0, 0, 0, 0, 0, 0, is_sw)); rdy_q.push_back(1);
      if (is_sw) return;
    end
    exp_q.push_back(mk(4, 0, 0, 0, 0, 0, 0, 1, is_r ? 1 : 0, (k == K_LW) ? 1 : 0, 0, 0, 0, 1));
    rdy_q.push_back(2);
  endtask

  // Driver: one clock of stimulus, sampled 1 time unit after the falling edge.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input bit z,
                      input int rmode, input logic [W-1:0] expv, input string tag);
    @(negedge clk);
    instr_op    = op;
    instr_funct = fn;
    alu_zero    = z;
    mem_ready   = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
    #1;
    check(tag, obs_vec(), expv);
  endtask

  task automatic run_instr(input int k, input int fw, input int mw, input bit z);
    logic [5:0] op, fn;
    int n;
    encode(k, op, fn);
    build_exp(k, fw, mw, z);
    n = exp_q.size();
    for (int i = 0; i < n; i++)
      step(op, fn, z, rdy_q[i], exp_q[i], $sformatf("%s fw%0d mw%0d cyc%0d", cls_name[k], fw, mw, i));
  endtask

  initial begin
    logic [5:0] op, fn;
    int nk;
    reset_n     = 1'b0;
    instr_op    = '0;
    instr_funct = '0;
    alu_zero    = 1'b0;
    mem_ready   = 1'b1;

    // Reset holds every output at zero even with mem_ready high.
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", obs_vec(), '0);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("post-reset fetch", obs_vec(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Directed steps from the test plan.
    run_instr(K_ORI, 0, 0, 0);
    run_instr(K_LW, 3, 2, 0);
    run_instr(K_BEQ, 0, 0, 1);
    run_instr(K_BEQ, 0, 0, 0);
    run_instr(K_JAL, 0, 0, 0);

    // Random instruction stream.
`ifdef MC_ILLEGAL_TRAP_EN
    nk = K_JAL;
`else
    nk = K_ILL;
`endif
    for (int n = 0; n < 60; n++)
      run_instr($urandom_range(0, nk), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));

    // Reset during a sw MEM wait: request and write drop immediately.
    encode(K_SW, op, fn);
    build_exp(K_SW, 0, 4, 0);
    for (int i = 0; i < 4; i++)
      step(op, fn, 1'b0, rdy_q[i], exp_q[i], $sformatf("sw abort cyc%0d", i));
    #2;
    reset_n = 1'b0;
    #1;
    check("abort mid-cycle", obs_vec(), '0);
    @(negedge clk);
    #1;
    check("abort held", obs_vec(), '0);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("abort release", obs_vec(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(K_J, 1, 0, 0);

    // Opcode 111111 is unrecognised.
`ifdef MC_ILLEGAL_TRAP_EN
    step(6'b111111, 6'b000000, 1'b0, 1, mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "trap fetch");
    step(6'b111111, 6'b000000, 1'b0, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "trap decode");
    for (int i = 0; i < 5; i++)
      step(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b1, 1,
           mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("trap hold %0d", i));
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("trap release", obs_vec(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
    step(6'b111111, 6'b000000, 1'b0, 1, mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "nop fetch");
    step(6'b111111, 6'b000000, 1'b0, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "nop decode");
`endif
    run_instr(K_ORI, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
